// File: rtl/unified_bus_arbiter.sv
// unified_bus_arbiter: one memory bus shared by an instruction and a data requester, with in-order read-response routing.
// Define BUS_ARBITER_ROUND_ROBIN_EN to replace fixed data priority with last-winner round-robin.
module unified_bus_arbiter #(
  parameter int unsigned TAG_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inst_address,
  input  logic        inst_read_enable,
  output logic        inst_wait_req,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  input  logic [31:0] data_address,
  input  logic [31:0] data_write_data,
  input  logic [3:0]  data_byte_enable,
  input  logic        data_read_enable,
  input  logic        data_write_enable,
  output logic        data_wait_req,
  output logic        data_valid,
  output logic [31:0] data_read_data,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byte_enable,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  input  logic        mem_wait_req,
  input  logic        mem_valid,
  input  logic [31:0] mem_read_data,
  output logic        response_error
);

  localparam int unsigned PW = $clog2(TAG_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD_DATA,
    HOLD_INST
  } state_t;

  state_t          state_q, state_d;
  logic            tag_q [TAG_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            error_q, error_d;

  logic            fifo_full, fifo_empty;
  logic            data_req, data_ok, inst_ok;
  logic            grant_data, grant_inst;
  logic            data_first;
  logic            mem_accept;
  logic            push, pop, pop_tag;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  logic            last_data_q, last_data_d;

  assign data_first  = ~last_data_q;
  assign last_data_d = mem_accept ? grant_data : last_data_q;
`else
  assign data_first  = 1'b1;
`endif

  assign fifo_full  = (count_q == CW'(TAG_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Reads are only eligible while a tag slot is free; writes never need one.
  assign data_req = data_read_enable | data_write_enable;
  assign data_ok  = data_req & (data_write_enable | ~fifo_full);
  assign inst_ok  = inst_read_enable & ~fifo_full;

  always_comb begin
    grant_data = 1'b0;
    grant_inst = 1'b0;
    if (!reset) begin
      case (state_q)
        HOLD_DATA: grant_data = data_ok;
        HOLD_INST: grant_inst = inst_ok;
        default: begin
          if (data_ok && (data_first || !inst_ok)) begin
            grant_data = 1'b1;
          end else if (inst_ok) begin
            grant_inst = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_address      = '0;
    mem_write_data   = '0;
    mem_byte_enable  = '0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    if (grant_data) begin
      mem_address      = data_address;
      mem_write_data   = data_write_data;
      mem_byte_enable  = data_byte_enable;
      mem_write_enable = data_write_enable;
      mem_read_enable  = data_read_enable & ~data_write_enable;
    end else if (grant_inst) begin
      mem_address      = inst_address;
      mem_byte_enable  = '1;
      mem_read_enable  = 1'b1;
    end
  end

  assign mem_accept    = (grant_data | grant_inst) & ~mem_wait_req;
  assign inst_wait_req = inst_read_enable & ~(grant_inst & mem_accept);
  assign data_wait_req = data_req & ~(grant_data & mem_accept);

  assign push       = mem_accept & mem_read_enable;
  assign pop        = mem_valid & ~fifo_empty & ~reset;
  assign pop_tag    = tag_q[rd_ptr_q];
  assign inst_valid = pop & ~pop_tag;
  assign data_valid = pop & pop_tag;

  assign inst_data      = mem_read_data;
  assign data_read_data = mem_read_data;
  assign response_error = error_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_data && mem_wait_req) begin
          state_d = HOLD_DATA;
        end else if (grant_inst && mem_wait_req) begin
          state_d = HOLD_INST;
        end
      end
      // A stalled read (tag FIFO full) keeps the hold; only acceptance releases it.
      HOLD_DATA: if (!data_req || mem_accept) state_d = IDLE;
      HOLD_INST: if (!inst_read_enable || mem_accept) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    error_d  = error_q | (mem_valid & fifo_empty);
  end

  always_ff @(posedge clock) begin
    if (push) begin
      tag_q[wr_ptr_q] <= grant_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      error_q     <= 1'b0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      error_q     <= error_d;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      last_data_q <= last_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_unified_bus_arbiter.sv
// Self-checking bench for unified_bus_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_unified_bus_arbiter;
  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst_address = '0;
  logic        inst_read_enable = 1'b0;
  logic        inst_wait_req, inst_valid;
  logic [31:0] inst_data;
  logic [31:0] data_address = '0, data_write_data = '0;
  logic [3:0]  data_byte_enable = '0;
  logic        data_read_enable = 1'b0, data_write_enable = 1'b0;
  logic        data_wait_req, data_valid;
  logic [31:0] data_read_data;
  logic [31:0] mem_address, mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_read_enable, mem_write_enable;
  logic        mem_wait_req = 1'b0, mem_valid = 1'b0;
  logic [31:0] mem_read_data = '0;
  logic        response_error;

  int vecs = 0;
  int errs = 0;

  unified_bus_arbiter #(.TAG_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .inst_address(inst_address), .inst_read_enable(inst_read_enable),
    .inst_wait_req(inst_wait_req), .inst_valid(inst_valid), .inst_data(inst_data),
    .data_address(data_address), .data_write_data(data_write_data),
    .data_byte_enable(data_byte_enable), .data_read_enable(data_read_enable),
    .data_write_enable(data_write_enable), .data_wait_req(data_wait_req),
    .data_valid(data_valid), .data_read_data(data_read_data),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_byte_enable(mem_byte_enable), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .mem_wait_req(mem_wait_req),
    .mem_valid(mem_valid), .mem_read_data(mem_read_data),
    .response_error(response_error)
  );

  always #5 clock = ~clock;

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic sample;
    @(negedge clock);
  endtask

  task automatic quiet;
    inst_read_enable  = 1'b0;
    data_read_enable  = 1'b0;
    data_write_enable = 1'b0;
    mem_wait_req      = 1'b0;
    mem_valid         = 1'b0;
  endtask

  task automatic test_reset;
    next_cycle;
    quiet;
    inst_read_enable = 1'b1;
    data_read_enable = 1'b1;
    mem_valid        = 1'b1;
    sample;
    vecs++; if (mem_read_enable !== 1'b0) begin errs++; $display("FAIL rst_re got %b want 0", mem_read_enable); end
    vecs++; if (inst_wait_req !== 1'b1) begin errs++; $display("FAIL rst_iwait got %b want 1", inst_wait_req); end
    vecs++; if (data_wait_req !== 1'b1) begin errs++; $display("FAIL rst_dwait got %b want 1", data_wait_req); end
    vecs++; if ({inst_valid, data_valid} !== 2'b00) begin errs++; $display("FAIL rst_valid got %b want 00", {inst_valid, data_valid}); end
    next_cycle;
    reset = 1'b0;
    quiet;
    sample;
    vecs++; if (response_error !== 1'b0) begin errs++; $display("FAIL rst_err got %b want 0", response_error); end
    vecs++; if ({mem_address, mem_read_enable, mem_write_enable} !== 34'd0) begin errs++; $display("FAIL rst_idle_bus got %h want 0", {mem_address, mem_read_enable, mem_write_enable}); end
  endtask

  task automatic test_inst_read;
    next_cycle;
    inst_address     = 32'h0000_1000;
    inst_read_enable = 1'b1;
    sample;
    vecs++; if (mem_read_enable !== 1'b1) begin errs++; $display("FAIL ird_re got %b want 1", mem_read_enable); end
    vecs++; if (mem_address !== 32'h0000_1000) begin errs++; $display("FAIL ird_addr got %h want 00001000", mem_address); end
    vecs++; if (inst_wait_req !== 1'b0) begin errs++; $display("FAIL ird_wait got %b want 0", inst_wait_req); end
    next_cycle;
    inst_read_enable = 1'b0;
    sample;
    vecs++; if (mem_read_enable !== 1'b0) begin errs++; $display("FAIL ird_re_off got %b want 0", mem_read_enable); end
    next_cycle;
    mem_valid     = 1'b1;
    mem_read_data = 32'h0000_0013;
    sample;
    vecs++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL ird_ivalid got %b want 1", inst_valid); end
    vecs++; if (inst_data !== 32'h0000_0013) begin errs++; $display("FAIL ird_idata got %h want 00000013", inst_data); end
    vecs++; if (data_valid !== 1'b0) begin errs++; $display("FAIL ird_dvalid got %b want 0", data_valid); end
    next_cycle;
    mem_valid = 1'b0;
    sample;
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL ird_pulse got %b want 0", inst_valid); end
  endtask

  task automatic test_contention;
    next_cycle;
    inst_address     = 32'h0000_2000;
    inst_read_enable = 1'b1;
    data_address     = 32'h0000_3000;
    data_read_enable = 1'b1;
    sample;
    vecs++; if (mem_address !== 32'h0000_3000) begin errs++; $display("FAIL cont_first got %h want 00003000", mem_address); end
    vecs++; if (inst_wait_req !== 1'b1) begin errs++; $display("FAIL cont_iwait got %b want 1", inst_wait_req); end
    vecs++; if (data_wait_req !== 1'b0) begin errs++; $display("FAIL cont_dwait got %b want 0", data_wait_req); end
    next_cycle;
    data_read_enable = 1'b0;
    sample;
    vecs++; if (mem_address !== 32'h0000_2000) begin errs++; $display("FAIL cont_second got %h want 00002000", mem_address); end
    vecs++; if (inst_wait_req !== 1'b0) begin errs++; $display("FAIL cont_iacc got %b want 0", inst_wait_req); end
    next_cycle;
    inst_read_enable = 1'b0;
    mem_valid        = 1'b1;
    mem_read_data    = 32'hAAAA_0000;
    sample;
    vecs++; if ({data_valid, inst_valid} !== 2'b10) begin errs++; $display("FAIL cont_resp1 got %b want 10", {data_valid, inst_valid}); end
    vecs++; if (data_read_data !== 32'hAAAA_0000) begin errs++; $display("FAIL cont_ddata got %h want aaaa0000", data_read_data); end
    next_cycle;
    mem_read_data = 32'h5555_FFFF;
    sample;
    vecs++; if ({data_valid, inst_valid} !== 2'b01) begin errs++; $display("FAIL cont_resp2 got %b want 01", {data_valid, inst_valid}); end
    vecs++; if (inst_data !== 32'h5555_FFFF) begin errs++; $display("FAIL cont_idata got %h want 5555ffff", inst_data); end
    next_cycle;
    mem_valid = 1'b0;
    sample;
  endtask

  task automatic test_round_robin;
    bit win_data [4];
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    win_data = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    win_data = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 5; i++) begin
      next_cycle;
      inst_address     = 32'h0000_4000;
      inst_read_enable = (i < 4);
      data_address     = 32'h0000_5000 + 32'(i * 4);
      data_read_enable = (i < 4);
      mem_valid        = (i > 0);
      mem_read_data    = $urandom;
      sample;
      if (i < 4) begin
        vecs++; if (mem_address !== (win_data[i] ? data_address : inst_address)) begin errs++; $display("FAIL rr_grant%0d got %h want %h", i, mem_address, win_data[i] ? data_address : inst_address); end
        vecs++; if ({data_wait_req, inst_wait_req} !== {!win_data[i], win_data[i]}) begin errs++; $display("FAIL rr_wait%0d got %b want %b", i, {data_wait_req, inst_wait_req}, {!win_data[i], win_data[i]}); end
      end
      if (i > 0) begin
        vecs++; if ({data_valid, inst_valid} !== {win_data[i-1], !win_data[i-1]}) begin errs++; $display("FAIL rr_resp%0d got %b want %b", i, {data_valid, inst_valid}, {win_data[i-1], !win_data[i-1]}); end
      end
    end
    next_cycle;
    quiet;
    sample;
  endtask

  task automatic test_fifo_full;
    for (int i = 0; i < 2; i++) begin
      next_cycle;
      data_address     = 32'h0000_0010 + 32'(i * 4);
      data_read_enable = 1'b1;
      sample;
      vecs++; if (data_wait_req !== 1'b0) begin errs++; $display("FAIL full_fill%0d got %b want 0", i, data_wait_req); end
    end
    next_cycle;
    data_address      = 32'h0000_0100;
    data_write_data   = 32'hDEAD_BEEF;
    data_byte_enable  = 4'hF;
    data_write_enable = 1'b1;
    sample;
    vecs++; if ({mem_write_enable, mem_read_enable} !== 2'b10) begin errs++; $display("FAIL full_wr_en got %b want 10", {mem_write_enable, mem_read_enable}); end
    vecs++; if ({mem_address, mem_write_data, mem_byte_enable} !== {32'h0000_0100, 32'hDEAD_BEEF, 4'hF}) begin errs++; $display("FAIL full_wr_bus got %h want 00000100deadbeeff", {mem_address, mem_write_data, mem_byte_enable}); end
    vecs++; if (data_wait_req !== 1'b0) begin errs++; $display("FAIL full_wr_wait got %b want 0", data_wait_req); end
    for (int i = 0; i < 3; i++) begin
      next_cycle;
      data_write_enable = 1'b0;
      data_address      = 32'h0000_0018;
      mem_valid         = (i == 1);
      sample;
      if (i < 2) begin
        vecs++; if ({data_wait_req, mem_read_enable} !== 2'b10) begin errs++; $display("FAIL full_stall%0d got %b want 10", i, {data_wait_req, mem_read_enable}); end
      end else begin
        vecs++; if ({data_wait_req, mem_read_enable, mem_address} !== {2'b01, 32'h0000_0018}) begin errs++; $display("FAIL full_resume got %h want 100000018", {data_wait_req, mem_read_enable, mem_address}); end
      end
      if (i == 1) begin
        vecs++; if (data_valid !== 1'b1) begin errs++; $display("FAIL full_pop got %b want 1", data_valid); end
      end
    end
    for (int i = 0; i < 2; i++) begin
      next_cycle;
      data_read_enable = 1'b0;
      mem_valid        = 1'b1;
      sample;
      vecs++; if (data_valid !== 1'b1) begin errs++; $display("FAIL full_drain%0d got %b want 1", i, data_valid); end
    end
    next_cycle;
    quiet;
    sample;
  endtask

  task automatic test_hold;
    next_cycle;
    data_address     = 32'h0000_0040;
    data_read_enable = 1'b1;
    mem_wait_req     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        next_cycle;
        inst_address     = 32'h0000_0080;
        inst_read_enable = 1'b1;
      end
      sample;
      vecs++; if ({mem_address, mem_read_enable} !== {32'h0000_0040, 1'b1}) begin errs++; $display("FAIL hold_addr%0d got %h want 00000040 re 1", i, {mem_address, mem_read_enable}); end
      vecs++; if (data_wait_req !== 1'b1) begin errs++; $display("FAIL hold_wait%0d got %b want 1", i, data_wait_req); end
    end
    next_cycle;
    mem_wait_req = 1'b0;
    sample;
    vecs++; if ({mem_address, data_wait_req, inst_wait_req} !== {32'h0000_0040, 2'b01}) begin errs++; $display("FAIL hold_accept got %h want 0000004001", {mem_address, data_wait_req, inst_wait_req}); end
    next_cycle;
    data_read_enable = 1'b0;
    sample;
    vecs++; if ({mem_address, inst_wait_req} !== {32'h0000_0080, 1'b0}) begin errs++; $display("FAIL hold_inst got %h want 0000008000", {mem_address, inst_wait_req}); end
    next_cycle;
    inst_read_enable = 1'b0;
    mem_valid        = 1'b1;
    sample;
    vecs++; if ({data_valid, inst_valid} !== 2'b10) begin errs++; $display("FAIL hold_resp1 got %b want 10", {data_valid, inst_valid}); end
    next_cycle;
    sample;
    vecs++; if ({data_valid, inst_valid} !== 2'b01) begin errs++; $display("FAIL hold_resp2 got %b want 01", {data_valid, inst_valid}); end
    next_cycle;
    quiet;
    sample;
  endtask

  task automatic test_error;
    next_cycle;
    mem_valid = 1'b1;
    sample;
    vecs++; if ({inst_valid, data_valid} !== 2'b00) begin errs++; $display("FAIL err_novalid got %b want 00", {inst_valid, data_valid}); end
    next_cycle;
    mem_valid = 1'b0;
    sample;
    vecs++; if (response_error !== 1'b1) begin errs++; $display("FAIL err_set got %b want 1", response_error); end
    next_cycle;
    data_address     = 32'h0000_0060;
    data_read_enable = 1'b1;
    sample;
    next_cycle;
    data_read_enable = 1'b0;
    inst_address     = 32'h0000_0064;
    inst_read_enable = 1'b1;
    sample;
    vecs++; if ({inst_wait_req, response_error} !== 2'b01) begin errs++; $display("FAIL err_sticky got %b want 01", {inst_wait_req, response_error}); end
    next_cycle;
    reset     = 1'b1;
    mem_valid = 1'b1;
    sample;
    vecs++; if ({inst_valid, data_valid, inst_wait_req, mem_read_enable} !== 4'b0010) begin errs++; $display("FAIL err_in_reset got %b want 0010", {inst_valid, data_valid, inst_wait_req, mem_read_enable}); end
    next_cycle;
    reset             = 1'b0;
    quiet;
    data_address      = 32'h0000_0070;
    data_byte_enable  = 4'hF;
    data_write_enable = 1'b1;
    sample;
    vecs++; if (response_error !== 1'b0) begin errs++; $display("FAIL err_clear got %b want 0", response_error); end
    vecs++; if ({mem_write_enable, mem_address} !== {1'b1, 32'h0000_0070}) begin errs++; $display("FAIL err_post_rst_wr got %h want 100000070", {mem_write_enable, mem_address}); end
    next_cycle;
    data_write_enable = 1'b0;
    mem_valid         = 1'b1;
    sample;
    vecs++; if ({inst_valid, data_valid} !== 2'b00) begin errs++; $display("FAIL err_flushed got %b want 00", {inst_valid, data_valid}); end
    next_cycle;
    mem_valid = 1'b0;
    sample;
    vecs++; if (response_error !== 1'b1) begin errs++; $display("FAIL err_reset_again got %b want 1", response_error); end
    next_cycle;
    reset = 1'b1;
    sample;
    vecs++; if (response_error !== 1'b1) begin errs++; $display("FAIL err_until_edge got %b want 1", response_error); end
  endtask

  // Model: outstanding owners in a queue (1 = data), plus which requester has been granted but not yet accepted.
  task automatic test_random;
    bit q[$];
    int lock = 0;
    int pick;
    bit prio_data = 1'b1;
    bit i_pend = 1'b0, d_pend = 1'b0;
    bit full, d_on, d_ok, i_ok, data_first, acc, e_re, e_we, e_iw, e_dw, e_iv, e_dv;
    logic [31:0] e_addr;
    int r;
    next_cycle;
    reset = 1'b0;
    quiet;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc > 0) next_cycle;
      if (!i_pend) begin
        inst_address     = $urandom;
        inst_read_enable = ($urandom_range(0, 2) != 0);
        i_pend           = inst_read_enable;
      end
      if (!d_pend) begin
        r                 = $urandom_range(0, 5);
        data_address      = $urandom;
        data_write_data   = $urandom;
        data_byte_enable  = 4'($urandom);
        data_read_enable  = (r == 2 || r == 3 || r == 5);
        data_write_enable = (r == 4 || r == 5);
        d_pend            = data_read_enable | data_write_enable;
      end
      mem_wait_req  = ($urandom_range(0, 3) == 0);
      mem_valid     = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_read_data = $urandom;
      sample;

      full = (q.size() == DEPTH);
      d_on = data_read_enable | data_write_enable;
      d_ok = d_on && (data_write_enable || !full);
      i_ok = inst_read_enable && !full;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      data_first = prio_data;
`else
      data_first = 1'b1;
`endif
      if (lock == 1) pick = d_ok ? 1 : 0;
      else if (lock == 2) pick = i_ok ? 2 : 0;
      else if (d_ok && (data_first || !i_ok)) pick = 1;
      else if (i_ok) pick = 2;
      else pick = 0;
      e_re   = (pick == 2) || (pick == 1 && data_read_enable && !data_write_enable);
      e_we   = (pick == 1) && data_write_enable;
      e_addr = (pick == 1) ? data_address : (pick == 2) ? inst_address : 32'd0;
      acc    = (pick != 0) && !mem_wait_req;
      e_iw   = inst_read_enable && !(acc && pick == 2);
      e_dw   = d_on && !(acc && pick == 1);
      e_iv   = mem_valid && q.size() > 0 && q[0] == 1'b0;
      e_dv   = mem_valid && q.size() > 0 && q[0] == 1'b1;

      vecs++; if ({mem_read_enable, mem_write_enable} !== {e_re, e_we}) begin errs++; $display("FAIL rand_en c%0d got %b want %b", cyc, {mem_read_enable, mem_write_enable}, {e_re, e_we}); end
      vecs++; if (mem_address !== e_addr) begin errs++; $display("FAIL rand_addr c%0d got %h want %h", cyc, mem_address, e_addr); end
      vecs++; if ({inst_wait_req, data_wait_req} !== {e_iw, e_dw}) begin errs++; $display("FAIL rand_wait c%0d got %b want %b", cyc, {inst_wait_req, data_wait_req}, {e_iw, e_dw}); end
      vecs++; if ({inst_valid, data_valid} !== {e_iv, e_dv}) begin errs++; $display("FAIL rand_valid c%0d got %b want %b", cyc, {inst_valid, data_valid}, {e_iv, e_dv}); end
      vecs++; if ({inst_data, data_read_data, response_error} !== {mem_read_data, mem_read_data, 1'b0}) begin errs++; $display("FAIL rand_rdata c%0d got %h want %h", cyc, {inst_data, data_read_data, response_error}, {mem_read_data, mem_read_data, 1'b0}); end

      if (mem_valid && q.size() > 0) void'(q.pop_front());
      if (acc && e_re) q.push_back(pick == 1);
      if (acc) begin
        lock      = 0;
        prio_data = (pick == 2);
        if (pick == 1) d_pend = 1'b0;
        if (pick == 2) i_pend = 1'b0;
      end else if (pick != 0) begin
        lock = pick;
      end
    end
  endtask

  initial begin
    test_reset;
    test_inst_read;
    test_contention;
    test_round_robin;
    test_fifo_full;
    test_hold;
    test_error;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/unified_bus_arbiter.md
UNIFIED_BUS_ARBITER -- requirements
Module: unified_bus_arbiter

Interface
REQ-001 Parameter: TAG_DEPTH, default 2, max outstanding reads (power of two, 2..8).
REQ-002 Ports, in order: clock in 1, the single clock; reset in 1, synchronous, active-high.
REQ-003 Instruction port: inst_address in 32; inst_read_enable in 1; inst_wait_req out 1; inst_valid out 1; inst_data out 32.
REQ-004 Data port: data_address in 32; data_write_data in 32; data_byte_enable in 4; data_read_enable in 1; data_write_enable in 1; data_wait_req out 1; data_valid out 1; data_read_data out 32.
REQ-005 Memory port: mem_address out 32; mem_write_data out 32; mem_byte_enable out 4; mem_read_enable out 1; mem_write_enable out 1; mem_wait_req in 1; mem_valid in 1; mem_read_data in 32.
REQ-006 Status: response_error out 1, sticky, set on an unexpected mem_valid.

Function
REQ-007 The block SHALL share one memory bus between instruction and data requesters. A request is accepted when an enable is high at the memory port and mem_wait_req is low.
REQ-008 Requesters SHALL hold address, data and enables stable while their wait_req is high.
REQ-009 FSM states SHALL be IDLE, HOLD_DATA and HOLD_INST.
REQ-010 In IDLE, the arbitration winner SHALL drive the memory port combinationally in the same cycle (zero added latency).
  - Accepted: stay in IDLE.
  - Not accepted (mem_wait_req high): go to HOLD_DATA or HOLD_INST as appropriate.
REQ-011 In HOLD_x, only requester x SHALL drive the memory port until acceptance; on acceptance go to IDLE; the grant SHALL NOT switch mid-request.
REQ-012 When no requester is driving, mem_read_enable and mem_write_enable SHALL be 0; address, data and byte enable SHALL be 0.
REQ-013 A requester's wait_req SHALL be high when its enable is high and it is not accepted that cycle; otherwise low.
REQ-014 A data request with both read and write enables high SHALL be treated as a write.
REQ-015 An accepted read SHALL push its owner (0 = inst, 1 = data) into a tag FIFO of depth TAG_DEPTH. Accepted writes push nothing and produce no valid.
REQ-016 A read SHALL NOT be presented to memory while the tag FIFO is full, even if a pop occurs in the same cycle; the requester sees wait_req high. Writes SHALL proceed while the FIFO is full.
REQ-017 Stall rule: if the FSM is in HOLD_x with a read and the FIFO becomes full, the memory enables SHALL drop and the state SHALL remain HOLD_x.
REQ-018 When mem_valid is high, the tag FIFO SHALL pop, and inst_valid or data_valid SHALL pulse for exactly that cycle according to the popped tag.
REQ-019 inst_data and data_read_data SHALL both equal mem_read_data combinationally.
REQ-020 mem_valid with an empty FIFO SHALL be dropped and SHALL set response_error.
REQ-021 Push and pop in the same cycle SHALL leave the occupancy unchanged. Pointers SHALL wrap modulo TAG_DEPTH.
REQ-022 Responses SHALL be routed strictly in acceptance order.

Reset
REQ-023 reset SHALL force, at the next clock edge:
  - state IDLE
  - FIFO empty, pointers 0
  - response_error 0
  - round-robin pointer to data
REQ-024 While reset is high, the memory enables, inst_valid and data_valid SHALL be 0, and both wait_req outputs SHALL be high whenever the corresponding enable is high.
REQ-025 Reset mid-transaction SHALL discard held grants and outstanding tags without generating valid pulses.

Configuration
REQ-026 Macro: BUS_ARBITER_ROUND_ROBIN_EN.
REQ-027 When the macro is defined, a 1-bit last-winner register SHALL be kept. When both requesters contend in IDLE, the one that did not win last SHALL be granted. The register updates on each acceptance.
REQ-028 When the macro is undefined, data SHALL always win contention in IDLE. No last-winner register SHALL exist.

Verification
REQ-029 Inst read only, mem_wait_req 0, read data returned 2 cycles later with 0x00000013 -> mem_read_enable high in the same cycle; inst_valid 1 for one cycle with inst_data 0x00000013; data_valid 0.
REQ-030 Inst and data reads in the same cycle, no macro -> data_address appears first and inst_wait_req is 1 that cycle; inst is accepted next cycle. Responses 0xAAAA0000 then 0x5555FFFF -> data_valid first, then inst_valid.
REQ-031 With the macro, 4 cycles of continuous contention (reads), mem_wait_req 0 -> grant order data, inst, data, inst.
REQ-032 TAG_DEPTH 2, three data reads with no mem_valid -> third read sees data_wait_req 1 and mem_read_enable 0. A data write at 0x100, byte enable 0xF, is accepted meanwhile. After one mem_valid, the third read is accepted next cycle.
REQ-033 Data read held with mem_wait_req 1 for 3 cycles while inst requests -> mem_address holds the data address all 3 cycles; inst is served after data is accepted.
REQ-034 mem_valid with an empty FIFO -> no valid pulse and response_error 1 until reset. Reset with 2 outstanding reads -> FIFO empty, state IDLE, no valid pulses.
